// File: rtl/jk_bank_sequencer.sv
// rtl/jk_bank_sequencer.sv - command-driven J/K excitation sequencer for a negedge JK flip-flop bank
module jk_bank_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  input  logic [7:0]       cmd_steps_i,
  input  logic [WIDTH-1:0] q_fb_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_UP    = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_VERIFY,
    S_FINISH
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] target;
  logic [7:0]       accept_cnt;

  // Next target value of the bank for one step of the given operation.
  function automatic logic [WIDTH-1:0] step_f(input logic [1:0]       op,
                                              input logic [WIDTH-1:0] data,
                                              input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    case (op)
      OP_CLEAR: r = '0;
      OP_LOAD:  r = data;
      OP_UP:    r = v + WIDTH'(1);
      default:  r = v - WIDTH'(1);
    endcase
    return r;
  endfunction

  // State and datapath registers; J/K drop to zero immediately on reset so the bank holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      op_q    <= OP_CLEAR;
      data_q  <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      j_q     <= j_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: accept, drive one step, verify the bank, repeat or finish.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    j_d        = j_q;
    k_d        = k_q;
    err_d      = err_q;
    target     = '0;
    accept_cnt = cmd_op_i[1] ? cmd_steps_i : 8'd1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d   = cmd_op_i;
          data_d = cmd_data_i;
          cnt_d  = accept_cnt;
          err_d  = 1'b0;
          if (accept_cnt == 8'd0) begin
            state_d = S_FINISH;
          end else begin
            target  = step_f(cmd_op_i, cmd_data_i, q_fb_i);
            exp_d   = target;
            j_d     = target & ~q_fb_i;
            k_d     = ~target & q_fb_i;
            state_d = S_DRIVE;
          end
        end
      end
      S_DRIVE: begin
        j_d     = '0;
        k_d     = '0;
        state_d = S_VERIFY;
      end
      S_VERIFY: begin
        cnt_d = cnt_q - 8'd1;
        if (q_fb_i != exp_q) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else if (cnt_q == 8'd1) begin
          state_d = S_FINISH;
        end else begin
          target  = step_f(op_q, data_q, exp_q);
          exp_d   = target;
          j_d     = target & ~q_fb_i;
          k_d     = ~target & q_fb_i;
          state_d = S_DRIVE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_FINISH);
  assign err_o       = err_q;
  assign j_o         = j_q;
  assign k_o         = k_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb/tb_jk_bank_sequencer.sv - scoreboard bench for jk_bank_sequencer with a JK bank model
module tb_jk_bank_sequencer;
  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [7:0]   cmd_steps;
  logic [W-1:0] j, k;
  logic         busy, done, err;
  logic [W-1:0] bank  = '0;
  logic [W-1:0] stuck = '0;
  int           cyc   = 0;
  int           tests = 0;
  int           fails = 0;

  typedef struct {
    logic         err;
    int           lat;
    logic [W-1:0] fin;
    logic [W-1:0] fj;
    logic [W-1:0] fk;
    int           acc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  jk_bank_sequencer #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_data_i  (cmd_data),
    .cmd_steps_i (cmd_steps),
    .q_fb_i      (bank),
    .j_o         (j),
    .k_o         (k),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  // Negative-edge JK flip-flop bank; stuck bits can never be set.
  always @(negedge clk) bank <= ((j & ~bank) | (~k & bank)) & ~stuck;
  always @(negedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Behavioural reference: walk the step sequence with integer arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] data,
                                 input logic [7:0] steps, input logic [W-1:0] start,
                                 input logic [W-1:0] stk);
    exp_t e;
    int   n, cur, tgt, after;
    bit   found;
    n = op[1] ? int'(steps) : 1;
    e.err = 1'b0; e.lat = 0; e.fin = start; e.fj = '0; e.fk = '0; e.acc = 0;
    cur = int'(start);
    found = 0;
    for (int s = 1; s <= n; s++) begin
      case (op)
        2'b00:   tgt = 0;
        2'b01:   tgt = int'(data);
        2'b10:   tgt = (cur + 1) % M;
        default: tgt = (cur + M - 1) % M;
      endcase
      if (!found && tgt != cur) begin
        found = 1;
        e.fj = W'(tgt & ~cur);
        e.fk = W'(~tgt & cur);
      end
      after = tgt & ~int'(stk);
      e.lat = 2 * s;
      e.fin = W'(after);
      if (after != tgt) begin
        e.err = 1'b1;
        break;
      end
      cur = tgt;
    end
    return e;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] data,
                       input logic [7:0] steps, input bit hold);
    int   g;
    exp_t e;
    g = 0;
    @(negedge clk);
    while (!cmd_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", 32'(cmd_ready), 32'd1);
    end else begin
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_steps = steps;
      @(posedge clk);
      e     = model(op, data, steps, bank, stuck);
      e.acc = cyc;
      sb.push_back(e);
      #1;
      if (!hold) cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on each DONE and checks invariants on every falling edge.
  logic         seen = 1'b0;
  logic [W-1:0] sj = '0, sk = '0;
  logic         prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (busy) check("j_and_k_exclusive", 32'(j & k), 32'd0);
      if (prev_done) check("done_one_cycle", 32'(done), 32'd0);
      if (busy && (j | k) != '0 && !seen) begin
        seen = 1'b1;
        sj   = j;
        sk   = k;
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("err", 32'(err), 32'(e.err));
          check("done_latency", 32'(cyc - e.acc), 32'(e.lat));
          check("bank_final", 32'(bank), 32'(e.fin));
          check("first_j", 32'(sj), 32'(e.fj));
          check("first_k", 32'(sk), 32'(e.fk));
        end
        seen = 1'b0;
        sj   = '0;
        sk   = '0;
      end
    end else begin
      seen = 1'b0;
    end
    prev_done = done & rst_n;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [1:0] op;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
    cmd_steps = '0;
    #2;
    check("rst_j", 32'(j), 32'd0);
    check("rst_k", 32'(k), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted in the middle of DRIVE.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'b0101;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("drive_j", 32'(j), 32'b0101);
    check("drive_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_j", 32'(j), 32'd0);
    check("midrst_k", 32'(k), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_bank_held", 32'(bank), 32'd0);

    // Directed scenarios.
    issue(2'b01, 4'b0110, 8'd0, 0);
    issue(2'b01, 4'b1010, 8'd0, 0);
    issue(2'b01, 4'b1110, 8'd0, 0);
    issue(2'b10, 4'b0000, 8'd3, 0);
    issue(2'b01, 4'b0000, 8'd0, 0);
    issue(2'b11, 4'b0000, 8'd2, 0);
    issue(2'b00, 4'b0000, 8'd0, 0);
    drain();
    stuck = 4'b0001;
    @(negedge clk);
    issue(2'b10, 4'b0000, 8'd5, 0);
    drain();
    stuck = '0;
    @(negedge clk);
    issue(2'b10, 4'b0000, 8'd0, 0);
    issue(2'b10, 4'b0000, 8'd3, 1);
    issue(2'b01, 4'b0011, 8'd0, 0);
    drain();

    // Randomized commands, occasionally with a stuck bit in the bank.
    for (int n = 0; n < 40; n++) begin
      stuck = ($urandom_range(0, 7) == 0) ? W'(1 << $urandom_range(0, W - 1)) : '0;
      @(negedge clk);
      op = 2'($urandom_range(0, 3));
      issue(op, W'($urandom), 8'($urandom_range(0, 5)), 0);
      drain();
    end
    stuck = '0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/jk_bank_sequencer.md
# jk_bank_sequencer

Synchronous controller that sequences an external bank of WIDTH negative-edge JK flip-flops sharing one CLK. It accepts commands over a valid/ready handshake: clear, load, count up, or count down a programmable number of steps. For each step it computes the per-bit J/K excitation from the flip-flop feedback, then checks the result after the flip-flops update. The block sits between the lab's command source (switches/debounced buttons or a test FSM) and the flip-flop bank, and reports completion and mismatch errors.

## Interface
- WIDTH, 4: number of flip-flops in the controlled bank (2..16).
- CLK  in  1: clock; controller updates on rising edge, flip-flop bank samples J/K on falling edge.
- RST_N  in  1: asynchronous, active-low reset.
- CMD_VALID  in  1: command request.
- CMD_READY  out  1: high only in IDLE; command accepted on rising edge with CMD_VALID & CMD_READY.
- CMD_OP  in  2: 00 clear, 01 load, 10 count up, 11 count down.
- CMD_DATA  in  WIDTH: load value (used only for op 01).
- CMD_STEPS  in  8: number of count steps (used only for ops 10/11).
- Q_FB  in  WIDTH: Q outputs of the flip-flop bank.
- J  out  WIDTH: J excitation, registered.
- K  out  WIDTH: K excitation, registered.
- BUSY  out  1: high in any state other than IDLE.
- DONE  out  1: one-cycle pulse at command completion.
- ERR  out  1: valid with DONE; 1 if any step's verification failed.

## Operation
- States: IDLE, DRIVE, VERIFY, FINISH.
- Excitation rule per bit i, for target value EXP and current Q_FB:
  - J[i] = EXP[i] & ~Q_FB[i]
  - K[i] = ~EXP[i] & Q_FB[i]
  - This never produces J=K=1; bits that already match get J=K=0 (hold).
- Step function f(op, v):
  - clear: 0.
  - load: CMD_DATA.
  - up: v+1 mod 2^WIDTH.
  - down: v-1 mod 2^WIDTH.
  - Wrap-around: all-ones up gives 0; 0 down gives all-ones.
- On accept, latch OP, DATA, and STEP_CNT:
  - STEP_CNT = 1 for clear/load.
  - STEP_CNT = CMD_STEPS for count ops.
- Accept with STEP_CNT = 0 (count op, CMD_STEPS = 0): go directly to FINISH. J/K stay 0, ERR = 0.
- Otherwise, on accept:
  - EXP <= f(OP, Q_FB).
  - J/K <= excitation(f(OP, Q_FB), Q_FB).
  - Go to DRIVE.
- DRIVE: lasts one cycle; the flip-flop bank updates on the falling edge within it. At the next rising edge, J/K <= 0 and go to VERIFY.
- VERIFY: at the next rising edge, compare Q_FB with EXP and decrement STEP_CNT.
  - Mismatch: set ERR, go to FINISH. Remaining steps are abandoned.
  - Match with STEP_CNT now 0: go to FINISH.
  - Match with steps left: EXP <= f(OP, EXP), J/K <= excitation(f(OP, EXP), Q_FB), go to DRIVE.
- FINISH: DONE = 1 for one cycle, ERR holds the result, then return to IDLE. ERR clears on the next accept.
- CMD_VALID while BUSY is ignored; no queueing.
- CMD_* inputs are sampled only at the accept edge; later changes have no effect.

## Timing
- Reset values (async, immediate):
  - state IDLE, J = 0, K = 0, BUSY = 0, DONE = 0, ERR = 0, EXP = 0, STEP_CNT = 0.
  - CMD_READY = 1 while in IDLE, including during reset.
- Single step, accepted at edge T:
  - J/K valid T..T+1.
  - J/K = 0 from T+1.
  - Q_FB checked at T+2.
  - DONE high T+2..T+3.
  - CMD_READY high again from T+3.
- N-step count: DONE high from T+2N for one cycle; total busy time 2N+1 cycles.
- Zero-step count: DONE high T..T+1 cycle window starting at T+1 edge? No — FINISH entered at T, so DONE is high from T to T+1.
- J/K change only on rising edges, so they are stable at every falling edge.
- Reset mid-operation: J/K go to 0 asynchronously, no DONE is produced, and the flip-flop bank keeps its state.

## Test plan
- Reset during DRIVE with J = 0101 → J, K = 0 immediately, BUSY = 0, CMD_READY = 1, no DONE pulse.
- Load CMD_DATA = 1010 with bank at 0110 → J = 1000, K = 0100 for one cycle; bank reads 1010; DONE at T+2, ERR = 0.
- Count up, CMD_STEPS = 3, from 1110 → bank sequence 1111, 0000, 0001 (wrap-around); DONE at T+6, ERR = 0.
- Count down, CMD_STEPS = 2, from 0000 → 1111, 1110; then clear → 0000 with K = 1110, J = 0000.
- Force Q_FB bit 0 stuck at 0 during count up from 0000 → ERR = 1 with DONE at T+2; no second DRIVE cycle.
- CMD_STEPS = 0 count → DONE on the cycle after accept, J/K never nonzero; CMD_VALID held high while BUSY during a 3-step count → no second accept until CMD_READY returns.
